// File: rtl/cpu3_pkg.sv
// cpu3_pkg: opcodes, select encodings, FSM states and decode shared by
// the 3-bit execute datapath and program_sequencer.
package cpu3_pkg;

  typedef enum logic [2:0] {
    OP_ADV = 3'd0,
    OP_BXL = 3'd1,
    OP_BST = 3'd2,
    OP_JNZ = 3'd3,
    OP_BXC = 3'd4,
    OP_OUT = 3'd5,
    OP_BDV = 3'd6,
    OP_CDV = 3'd7
  } opcode_e;

  localparam logic [1:0] COMBO_OP_SEL = 2'd0;
  localparam logic [1:0] LIT_OP_SEL   = 2'd1;
  localparam logic [1:0] REG_B_SEL    = 2'd2;
  localparam logic [1:0] REG_C_SEL    = 2'd3;

  localparam logic [1:0] SHIFT_SEL = 2'd0;
  localparam logic [1:0] XOR_SEL   = 2'd1;
  localparam logic [1:0] MOD_SEL   = 2'd2;

  localparam logic [4:0] WR_A   = 5'b00001;
  localparam logic [4:0] WR_B   = 5'b00010;
  localparam logic [4:0] WR_C   = 5'b00100;
  localparam logic [4:0] WR_OUT = 5'b01000;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_READY,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [1:0] op1_sel;
    logic [1:0] op2_sel;
    logic [1:0] operation_sel;
    logic [4:0] reg_wr_en;
  } ctrl_t;

  function automatic ctrl_t decode(input opcode_e op);
    ctrl_t c;
    c = '0;
    unique case (1'b1)
      op == OP_ADV: begin
        c.operation_sel = SHIFT_SEL;
        c.reg_wr_en = WR_A;
      end
      op == OP_BXL: begin
        c.op1_sel = REG_B_SEL;
        c.op2_sel = LIT_OP_SEL;
        c.operation_sel = XOR_SEL;
        c.reg_wr_en = WR_B;
      end
      op == OP_BST: begin
        c.op1_sel = COMBO_OP_SEL;
        c.operation_sel = MOD_SEL;
        c.reg_wr_en = WR_B;
      end
      op == OP_JNZ: ;
      op == OP_BXC: begin
        c.op1_sel = REG_B_SEL;
        c.op2_sel = REG_C_SEL;
        c.operation_sel = XOR_SEL;
        c.reg_wr_en = WR_B;
      end
      op == OP_OUT: begin
        c.op1_sel = COMBO_OP_SEL;
        c.operation_sel = MOD_SEL;
        c.reg_wr_en = WR_OUT;
      end
      op == OP_BDV: begin
        c.operation_sel = SHIFT_SEL;
        c.reg_wr_en = WR_B;
      end
      op == OP_CDV: begin
        c.operation_sel = SHIFT_SEL;
        c.reg_wr_en = WR_C;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/out_fifo.sv
// out_fifo: synchronous FIFO with occupancy count.
// Ports: push/din in, pop in, dout (head), count, empty out.
module out_fifo #(
  parameter int W     = 3,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [W-1:0]           din,
  input  logic                   pop,
  output logic [W-1:0]           dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: loads 3-bit program words, decodes at instr_ptr,
// gates the datapath and buffers its out values through a FIFO.
module program_sequencer
  import cpu3_pkg::*;
#(
  parameter int PROG_LEN  = 16,
  parameter int OUT_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [2:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  input  logic       start,
  input  logic [3:0] instr_ptr,
  input  logic       halt,
  input  logic [2:0] exec_out,
  output logic       exec_en,
  output logic [2:0] operand_id_reg,
  output logic [1:0] op1_sel,
  output logic [1:0] op2_sel,
  output logic [1:0] operation_sel,
  output logic [4:0] reg_wr_en,
  output logic [2:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam int AW = $clog2(PROG_LEN);
  localparam int CW = $clog2(OUT_DEPTH) + 1;

  state_e        state;
  state_e        state_nx;
  logic [2:0]    mem [PROG_LEN];
  logic [AW-1:0] wr_ptr;
  logic [3:0]    opnd_addr;
  opcode_e       opcode;
  ctrl_t         ctrl;
  logic          run;
  logic          load_fire;
  logic          stall;
  logic          issue_out;
  logic          out_pending;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   fill;

  assign opnd_addr = instr_ptr + 4'd1;
  assign opcode    = opcode_e'(mem[instr_ptr]);
  assign load_fire = load_valid && load_ready;
  assign out_valid = !fifo_empty;

  // A pending push already owns a slot; a same-cycle pop is not credited.
  assign fill  = (CW+1)'(fifo_count) + (CW+1)'(out_pending);
  assign stall = (opcode == OP_OUT) && (fill >= (CW+1)'(OUT_DEPTH));

  assign issue_out = exec_en && (opcode == OP_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_LOAD;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_LOAD:
        if (load_fire &&
            (load_last || wr_ptr == AW'(PROG_LEN - 1)))
          state_nx = ST_READY;
      ST_READY:
        if (start) state_nx = ST_RUN;
      ST_RUN:
        if (halt) state_nx = ST_DRAIN;
      ST_DRAIN:
        if (fifo_empty && !out_pending) state_nx = ST_DONE;
      ST_DONE: ;
      default: state_nx = ST_LOAD;
    endcase
  end

  always_comb begin
    load_ready = 1'b0;
    run        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      ST_LOAD:  load_ready = 1'b1;
      ST_RUN: begin
        run  = 1'b1;
        busy = 1'b1;
      end
      ST_DRAIN: busy = 1'b1;
      ST_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ctrl           = '0;
    operand_id_reg = '0;
    exec_en        = 1'b0;
    if (run) begin
      ctrl           = decode(opcode);
      operand_id_reg = mem[opnd_addr];
      exec_en        = !halt && !stall;
    end
  end

  assign op1_sel       = ctrl.op1_sel;
  assign op2_sel       = ctrl.op2_sel;
  assign operation_sel = ctrl.operation_sel;
  assign reg_wr_en     = ctrl.reg_wr_en & {5{exec_en}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < PROG_LEN; i++) mem[i] <= '0;
      wr_ptr <= '0;
    end else if (load_fire) begin
      mem[wr_ptr] <= load_data;
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  // The datapath's output register updates on the issue edge, so
  // exec_out is captured one cycle later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_pending <= 1'b0;
    else        out_pending <= issue_out;
  end

  out_fifo #(
    .W     (3),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (out_pending),
    .din   (exec_out),
    .pop   (out_valid && out_ready),
    .dout  (out_data),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed bench with a behavioural model of the
// 3-bit execute datapath driving instr_ptr/halt/exec_out.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [2:0] load_data = '0;
  logic       load_last = 1'b0;
  logic       load_ready;
  logic       start = 1'b0;
  logic [3:0] instr_ptr;
  logic       halt;
  logic [2:0] exec_out;
  logic       exec_en;
  logic [2:0] operand_id_reg;
  logic [1:0] op1_sel;
  logic [1:0] op2_sel;
  logic [1:0] operation_sel;
  logic [4:0] reg_wr_en;
  logic [2:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  program_sequencer #(
    .PROG_LEN  (16),
    .OUT_DEPTH (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_valid     (load_valid),
    .load_data      (load_data),
    .load_last      (load_last),
    .load_ready     (load_ready),
    .start          (start),
    .instr_ptr      (instr_ptr),
    .halt           (halt),
    .exec_out       (exec_out),
    .exec_en        (exec_en),
    .operand_id_reg (operand_id_reg),
    .op1_sel        (op1_sel),
    .op2_sel        (op2_sel),
    .operation_sel  (operation_sel),
    .reg_wr_en      (reg_wr_en),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .done           (done)
  );

  // ---- datapath model ----
  logic [2:0]  prog [16];
  logic [31:0] dp_a0 = '0;
  int          dp_len = 16;
  int          dp_halt_at = -1;
  logic [31:0] a, b, c;
  int          dp_ip;
  logic [2:0]  out_reg;
  int          dp_out_cnt;
  logic [2:0]  dp_op, dp_lit;
  logic [31:0] dp_cv;

  assign instr_ptr = dp_ip[3:0];
  assign halt      = (dp_ip >= dp_len) || (dp_ip == dp_halt_at);
  assign exec_out  = out_reg;
  assign dp_op     = prog[dp_ip[3:0]];
  assign dp_lit    = prog[dp_ip[3:0] + 4'd1];

  always_comb begin
    dp_cv = {29'd0, dp_lit};
    case (dp_lit)
      3'd4: dp_cv = a;
      3'd5: dp_cv = b;
      3'd6: dp_cv = c;
      default: ;
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= dp_a0;
      b <= '0;
      c <= '0;
      dp_ip <= 0;
      out_reg <= '0;
      dp_out_cnt <= 0;
    end else if (exec_en) begin
      dp_ip <= dp_ip + 2;
      case (dp_op)
        3'd0: a <= a >> dp_cv;
        3'd1: b <= b ^ {29'd0, dp_lit};
        3'd2: b <= dp_cv % 8;
        3'd3: if (a != 0) dp_ip <= int'(dp_lit);
        3'd4: b <= b ^ c;
        3'd5: begin
          out_reg <= dp_cv[2:0];
          dp_out_cnt <= dp_out_cnt + 1;
        end
        3'd6: b <= a >> dp_cv;
        default: c <= a >> dp_cv;
      endcase
    end
  end

  // ---- helpers ----
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] a0, input int len,
                          input int hat);
    dp_a0 = a0;
    dp_len = len;
    dp_halt_at = hat;
    load_valid = 0;
    load_last = 0;
    start = 0;
    out_ready = 0;
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
  endtask

  // words listed first-to-last, packed MSB-first into the low 3*n bits
  task automatic load_prog(input logic [47:0] words, input int n,
                           input bit mark_last);
    for (int i = 0; i < 16; i++) prog[i] = '0;
    for (int i = 0; i < n; i++) begin
      load_valid = 1;
      load_data = words[3*(n-1-i) +: 3];
      load_last = mark_last && (i == n - 1);
      prog[i] = load_data;
      tick();
    end
    load_valid = 0;
    load_last = 0;
  endtask

  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask

  int exp1 [10] = '{4, 6, 3, 5, 6, 3, 5, 2, 1, 0};

  initial begin
    int k, first_valid, halt_busy, pops, adv_seen, cnt14;

    // ---- reset values ----
    rst_n = 0;
    #2;
    check("rst_load_ready", 32'(load_ready), 1);
    check("rst_exec_en", 32'(exec_en), 0);
    check("rst_wr_en", 32'(reg_wr_en), 0);
    check("rst_sels", 32'({op1_sel, op2_sel, operation_sel}), 0);
    check("rst_operand", 32'(operand_id_reg), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy_done", 32'({busy, done}), 0);

    // ---- example program, A=729 ----
    do_reset(32'd729, 6, -1);
    load_prog({3'd0, 3'd1, 3'd5, 3'd4, 3'd3, 3'd0}, 6, 1);
    check("t1_ready_state", 32'({load_ready, busy, done}), 0);
    out_ready = 1;
    pulse_start();
    check("t1_exec_en", 32'(exec_en), 1);
    check("t1_wr_adv", 32'(reg_wr_en), 32'h01);
    check("t1_busy", 32'(busy), 1);
    k = 0;
    first_valid = -1;
    halt_busy = 0;
    for (int n = 0; n < 200; n++) begin
      if (done) break;
      if (out_valid && first_valid < 0) first_valid = n;
      if (busy && halt) halt_busy++;
      if (out_valid && out_ready) begin
        if (k < 10) check("t1_out", 32'(out_data), 32'(exp1[k]));
        k++;
      end
      tick();
    end
    check("t1_latency", 32'(first_valid), 3);
    check("t1_count", 32'(k), 10);
    check("t1_drain", 32'(halt_busy), 2);
    check("t1_done", 32'({done, busy}), 32'b10);

    // ---- bxl decode, start in LOAD, load in READY/RUN ----
    do_reset(32'd0, 2, -1);
    pulse_start();
    check("t2_start_in_load", 32'({load_ready, busy}), 32'b10);
    load_prog({3'd1, 3'd7}, 2, 1);
    check("t2_ready", 32'(load_ready), 0);
    load_valid = 1;
    load_data = 3'd4;
    tick();
    check("t2_no_ready_ready", 32'(load_ready), 0);
    pulse_start();
    check("t2_op1", 32'(op1_sel), 2);
    check("t2_op2", 32'(op2_sel), 1);
    check("t2_opsel", 32'(operation_sel), 1);
    check("t2_wr", 32'(reg_wr_en), 32'b00010);
    check("t2_operand", 32'(operand_id_reg), 7);
    check("t2_no_ready_run", 32'(load_ready), 0);
    tick();
    check("t2_halt_gate", 32'({exec_en, reg_wr_en}), 0);
    check("t2_mem2_zero", 32'({op1_sel, op2_sel}), 0);
    load_valid = 0;
    for (int n = 0; n < 20 && !done; n++) tick();
    check("t2_done", 32'(done), 1);

    // ---- backpressure stall ----
    do_reset(32'd729, 4, -1);
    load_prog({3'd5, 3'd4, 3'd3, 3'd0}, 4, 1);
    pulse_start();
    for (int n = 0; n < 40; n++) tick();
    check("t3_pushes", 32'(dp_out_cnt), 8);
    check("t3_stalled", 32'(exec_en), 0);
    check("t3_ip_frozen", 32'(instr_ptr), 0);
    check("t3_head", 32'({out_valid, out_data}), 32'b1001);
    out_ready = 1;
    #1;
    check("t3_pop_no_relief", 32'(exec_en), 0);
    pops = 0;
    for (int n = 0; n < 30; n++) begin
      if (out_valid && out_ready) begin
        check("t3_stream", 32'(out_data), 1);
        pops++;
      end
      tick();
    end
    out_ready = 0;
    for (int n = 0; n < 30; n++) tick();
    check("t3_conserve", 32'(dp_out_cnt), 32'(pops + 8));
    check("t3_restall", 32'(exec_en), 0);
    dp_halt_at = 2;
    out_ready = 1;
    for (int n = 0; n < 60; n++) begin
      if (done) break;
      if (out_valid && out_ready) pops++;
      tick();
    end
    check("t3_done", 32'(done), 1);
    check("t3_all_popped", 32'(pops), 32'(dp_out_cnt));

    // ---- unloaded words decode as adv 0, halt at 14 ----
    do_reset(32'd0, 16, 14);
    load_prog({3'd1, 3'd2, 3'd3, 3'd4}, 4, 1);
    check("t4_ready", 32'(load_ready), 0);
    pulse_start();
    check("t4_operand0", 32'(operand_id_reg), 2);
    adv_seen = 0;
    cnt14 = 0;
    for (int n = 0; n < 40; n++) begin
      if (done) break;
      if (busy && exec_en && instr_ptr >= 4) begin
        check("t4_adv", 32'({op1_sel, op2_sel, operation_sel,
                             operand_id_reg, reg_wr_en}), 32'h01);
        adv_seen++;
      end
      if (busy && instr_ptr == 14) begin
        cnt14++;
        check("t4_halt_gate", 32'({exec_en, reg_wr_en}), 0);
      end
      tick();
    end
    check("t4_adv_count", 32'(adv_seen), 5);
    check("t4_run_drain", 32'(cnt14), 2);
    check("t4_done", 32'(done), 1);

    // ---- reset mid-RUN ----
    do_reset(32'd729, 4, -1);
    load_prog({3'd5, 3'd4, 3'd3, 3'd0}, 4, 1);
    pulse_start();
    for (int n = 0; n < 40; n++) begin
      if (dp_out_cnt >= 4) break;
      tick();
    end
    check("t5_issued", 32'(dp_out_cnt), 4);
    check("t5_fifo_busy", 32'({out_valid, busy}), 32'b11);
    dp_len = 1;
    rst_n = 0;
    #1;
    check("t5_rst_state", 32'({load_ready, busy, done}), 32'b100);
    check("t5_rst_fifo", 32'({out_valid, out_data}), 0);
    check("t5_rst_exec", 32'(exec_en), 0);
    tick();
    rst_n = 1;
    tick();
    check("t5_no_push", 32'(out_valid), 0);
    load_prog({3'd1}, 1, 1);
    pulse_start();
    check("t5_mem_cleared", 32'(operand_id_reg), 0);
    check("t5_bxl", 32'(op1_sel), 2);
    for (int n = 0; n < 20 && !done; n++) tick();
    check("t5_done", 32'(done), 1);

    // ---- full-depth load without load_last ----
    do_reset(32'd0, 16, -1);
    load_valid = 1;
    load_data = 3'd6;
    for (int i = 0; i < 15; i++) tick();
    check("t6_ready_at_15", 32'(load_ready), 1);
    tick();
    load_valid = 0;
    check("t6_ready_at_16", 32'(load_ready), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
